// File: rtl/lmc_loader_pkg.sv
// Shared types and constants for the LMC program loader.
//   state_t      : loader FSM encodings
//   LMC_HDR      : frame header byte
//   lmc_max_len  : largest legal LEN for a given address width (RAM depth)
package lmc_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_CSUM = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_t;

  localparam logic [7:0] LMC_HDR = 8'hA5;

  // A frame may fill the whole program RAM but never more.
  function automatic int unsigned lmc_max_len(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/lmc_csum_acc.sv
// 8-bit wrapping additive accumulator with synchronous clear and add-enable.
// Ports:
//   clk, reset_count : clock, async active-high reset
//   clr              : clear sum (wins over add_en)
//   add_en, din      : add din into the running sum
//   sum              : registered running sum mod 256
module lmc_csum_acc (
  input  logic       clk,
  input  logic       reset_count,
  input  logic       clr,
  input  logic       add_en,
  input  logic [7:0] din,
  output logic [7:0] sum
);

  always_ff @(posedge clk or posedge reset_count) begin
    if (reset_count)  sum <= 8'd0;
    else if (clr)     sum <= 8'd0;
    else if (add_en)  sum <= sum + din;
  end

endmodule

// File: rtl/lmc_prog_loader.sv
// Program loader: accepts framed bytes (HDR, LEN, payload, [CSUM]), writes
// payload into the core's program RAM and holds the core in reset until a
// frame loads cleanly.
// Build option: LMC_LOADER_CSUM_EN adds the trailing checksum byte and check.
// Ports:
//   clk, reset_count          : clock, async active-high reset
//   byte_valid/data/ready     : input byte stream (never stalls)
//   mem_we/addr/wdata         : one-cycle RAM write port
//   cpu_reset                 : hold core in reset (low only when loaded)
//   load_done, load_error     : last frame verified / rejected
//   words_loaded              : payload words written in current/last frame
module lmc_prog_loader
  import lmc_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 2,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_count,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  cpu_reset,
  output logic                  load_done,
  output logic                  load_error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam int unsigned LW      = ADDR_WIDTH + 1;
  localparam int unsigned MAX_LEN = lmc_max_len(ADDR_WIDTH);

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LW-1:0]         len_q;
  logic                  accept;
  logic                  do_start;
  logic                  do_write;
  logic                  len_bad;
  logic                  last_word;

  assign accept    = byte_valid & byte_ready;
  assign len_bad   = (byte_data == 8'd0) || (32'(byte_data) > MAX_LEN);
  assign last_word = (LW'(words_loaded + LW'(1)) == len_q);

`ifdef LMC_LOADER_CSUM_EN
  logic [7:0] sum;

  lmc_csum_acc u_csum (
    .clk         (clk),
    .reset_count (reset_count),
    .clr         (do_start),
    .add_en      (do_write),
    .din         (byte_data),
    .sum         (sum)
  );
`endif

  // State register
  always_ff @(posedge clk or posedge reset_count) begin
    if (reset_count) state <= ST_IDLE;
    else             state <= state_next;
  end

  // Next-state and per-byte control
  always_comb begin
    state_next = state;
    do_start   = 1'b0;
    do_write   = 1'b0;
    if (accept) begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (byte_data == LMC_HDR) state_next = ST_LEN;
        end
        ST_LEN: begin
          do_start   = 1'b1;
          state_next = len_bad ? ST_ERR : ST_DATA;
        end
        ST_DATA: begin
          // A header value here is payload, not a restart.
          do_write = 1'b1;
          if (last_word) begin
`ifdef LMC_LOADER_CSUM_EN
            state_next = ST_CSUM;
`else
            state_next = ST_DONE;
`endif
          end
        end
`ifdef LMC_LOADER_CSUM_EN
        ST_CSUM: begin
          state_next = (byte_data == sum) ? ST_DONE : ST_ERR;
        end
`endif
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Datapath and registered status, all timed off the next state
  always_ff @(posedge clk or posedge reset_count) begin
    if (reset_count) begin
      byte_ready   <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      cpu_reset    <= 1'b1;
      load_done    <= 1'b0;
      load_error   <= 1'b0;
      words_loaded <= '0;
      addr_q       <= '0;
      len_q        <= '0;
    end else begin
      byte_ready <= 1'b1;
      mem_we     <= do_write;
      cpu_reset  <= (state_next != ST_DONE);
      load_done  <= (state_next == ST_DONE);
      load_error <= (state_next == ST_ERR);
      if (do_start) begin
        addr_q       <= '0;
        words_loaded <= '0;
        len_q        <= LW'(byte_data);
      end
      if (do_write) begin
        mem_addr  <= addr_q;
        mem_wdata <= DATA_WIDTH'(byte_data);
        addr_q    <= addr_q + ADDR_WIDTH'(1);
        if (words_loaded < len_q) words_loaded <= words_loaded + LW'(1);
      end
    end
  end

endmodule
